// File: rtl/lfsr_if.sv
// Request/data bundle between a consumer and the lfsr random-byte generator.
// The consumer drives the advance request and seed; the generator returns the byte.
interface lfsr_if #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 8
);
   logic                 next;
   logic [WIDTH-1:0]     seed;
   logic [OUT_WIDTH-1:0] rnd;

   modport master (
      output next,
      output seed,
      input  rnd
   );

   modport slave (
      input  next,
      input  seed,
      output rnd
   );
endinterface

// File: rtl/lfsr.sv
// Pseudo-random byte generator: 16-bit maximal-length Fibonacci LFSR that is
// seeded once after reset and advanced eight shift steps per request.
module lfsr #(
   parameter int          WIDTH         = 16,
   parameter int          OUT_WIDTH     = 8,
   parameter logic [15:0] FALLBACK_SEED = 16'hACE1
) (
   input  logic  clk,
   input  logic  rst_n,
   lfsr_if.slave bus
);

   // Polynomial x^16 + x^14 + x^13 + x^11 + 1; taps are fixed for a 16-bit state.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      logic fb;
      fb = s[15] ^ s[13] ^ s[12] ^ s[10];
      return {s[WIDTH-2:0], fb};
   endfunction

   logic [WIDTH-1:0] state_r;
   logic             loaded_r;
   logic [WIDTH-1:0] adv_s;
   logic [WIDTH-1:0] load_val_s;

   // Unrolled chain of OUT_WIDTH single steps so every advance exposes a fresh byte.
   always_comb begin
      adv_s = state_r;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         adv_s = lfsr_step(adv_s);
      end
   end

   // An all-zero seed would lock the LFSR up, so substitute the fallback.
   always_comb begin
      if (bus.seed == {WIDTH{1'b0}}) begin
         load_val_s = FALLBACK_SEED;
      end else begin
         load_val_s = bus.seed;
      end
   end

   // State register: load once after reset, then advance or hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= {WIDTH{1'b0}};
         loaded_r <= 1'b0;
      end else if (!loaded_r) begin
         state_r  <= load_val_s;
         loaded_r <= 1'b1;
      end else if (bus.next) begin
         state_r  <= adv_s;
         loaded_r <= 1'b1;
      end else begin
         state_r  <= state_r;
         loaded_r <= 1'b1;
      end
   end

   assign bus.rnd = state_r[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_lfsr.sv
// Self-checking bench for lfsr: vector table plus hand-written reset, zero-seed,
// mid-run reset and full-period sequences, all checked through a scoreboard queue.
module tb_lfsr;

   logic clk;
   logic rst_n;

   lfsr_if #(.WIDTH(16), .OUT_WIDTH(8)) bus ();

   lfsr #(.WIDTH(16), .OUT_WIDTH(8), .FALLBACK_SEED(16'hACE1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       nxt;
      logic [7:0] exp;
   } vec_t;

   int         checks;
   int         errors;
   logic [7:0] exp_q[$];
   logic [15:0] ms;

   // Reference: feedback is the parity of the tap positions (mask 0xB400).
   function automatic logic [15:0] ref_adv(input logic [15:0] s);
      logic [15:0] t;
      t = s;
      repeat (8) t = (t << 1) | {15'd0, ^(t & 16'hB400)};
      return t;
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: rnd=%h expected %h", name, act, req);
      end
   endtask

   task automatic check32(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Drive one cycle, queue its expected byte, then pop and compare after the edge.
   task automatic cycle(input logic n, input logic [7:0] e, input string name);
      logic [7:0] want;
      bus.next = n;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check8(name, bus.rnd, want);
   endtask

   task automatic reset_and_load(input logic [15:0] sd, input logic nxt_on_load);
      @(negedge clk);
      bus.seed = sd;
      bus.next = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      check8("in_reset", bus.rnd, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      ms    = (sd == 16'h0000) ? 16'hACE1 : sd;
      cycle(nxt_on_load, ms[7:0], "load");
   endtask

   vec_t tbl[16];
   int   zero_seen;
   int   early;
   int   perr;

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      bus.next = 1'b0;
      bus.seed = 16'hFFFF;

      // Reset state before any clock edge
      #2;
      check8("reset_rnd", bus.rnd, 8'h00);

      // Table: seeded from 0xFFFF; fixed points first, model continues the rest
      tbl[0] = '{1'b0, 8'hFF};
      tbl[1] = '{1'b1, 8'h00};
      tbl[2] = '{1'b1, 8'h1B};
      for (int i = 3; i < 8; i++) tbl[i] = '{1'b0, 8'h1B};
      ms = 16'h001B;
      for (int i = 8; i < 16; i++) begin
         tbl[i].nxt = (i % 3 != 0);
         if (tbl[i].nxt) ms = ref_adv(ms);
         tbl[i].exp = ms[7:0];
      end

      reset_and_load(16'hFFFF, 1'b0);
      for (int i = 0; i < 16; i++) cycle(tbl[i].nxt, tbl[i].exp, $sformatf("vec%0d", i));

      // Zero seed falls back to 0xACE1
      reset_and_load(16'h0000, 1'b0);
      checks++;
      if (dut.state_r !== 16'hACE1) begin
         errors++;
         $display("FAIL fallback_state: state=%h expected %h", dut.state_r, 16'hACE1);
      end
      for (int i = 0; i < 4; i++) begin
         ms = ref_adv(ms);
         cycle(1'b1, ms[7:0], "zero_seed_adv");
      end

      // Asynchronous reset mid-run, next high on the load edge is ignored
      #3;
      rst_n    = 1'b0;
      bus.seed = 16'h1234;
      #1;
      check8("async_reset", bus.rnd, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 8'h34, "reload_ignore_next");
      ms = ref_adv(16'h1234);
      cycle(1'b1, ms[7:0], "after_reload");
      bus.seed = 16'hBEEF;
      ms = ref_adv(ms);
      cycle(1'b1, ms[7:0], "seed_change_ignored");

      // Full period from seed 0x0001
      reset_and_load(16'h0001, 1'b0);
      bus.next  = 1'b1;
      zero_seen = 0;
      early     = 0;
      perr      = 0;
      for (int i = 1; i <= 65535; i++) begin
         @(posedge clk);
         #1;
         ms = ref_adv(ms);
         if (bus.rnd !== ms[7:0]) perr++;
         if (dut.state_r == 16'h0000) zero_seen++;
         if (dut.state_r == 16'h0001 && i < 65535) early++;
      end
      bus.next = 1'b0;
      check32("period_bytes", perr, 0);
      check32("period_zero", zero_seen, 0);
      check32("period_early", early, 0);
      checks++;
      if (dut.state_r !== 16'h0001) begin
         errors++;
         $display("FAIL period_return: state=%h expected %h", dut.state_r, 16'h0001);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
